// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, one recoded digit per clock, with early
// exit once all remaining multiplier digits are zero.
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   start, signed_mode : launch request (ignored while busy), operand signedness
//   a, b               : multiplicand, multiplier (WIDTH bits)
//   busy, done         : RUN indicator, one-cycle product-valid pulse
//   product            : 2*WIDTH-bit result, held until the next accepted start
//   add_count          : number of +1/+2 digits applied
//   sub_count          : number of -1/-2 digits applied
module booth_r4_mult #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned NDIG = WIDTH / 2 + 1,
  localparam int unsigned CW   = $clog2(NDIG + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [CW-1:0]        add_count,
  output logic [CW-1:0]        sub_count
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned BW = WIDTH + 2;   // bext[WIDTH:0] plus bext[-1]

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]    state_q;
  logic [1:0]    state_n;
  logic [BW-1:0] bsh_q;    // bsh_q[k] = bext[2i+k-1], sign-filled on shift
  logic [PW-1:0] msh_q;    // aext * 4^i, extended to product width
  logic [CW-1:0] idx_q;

  logic          accept_c;
  logic          pos_c;
  logic          neg_c;
  logic          two_c;
  logic          rest_same_c;
  logic          last_c;
  logic [PW-1:0] pp_c;
  logic [PW-1:0] prod_next_c;

  assign accept_c = start && (state_q != RUN);

  // Booth recoding of the current 3-bit window
  always_comb begin
    pos_c = 1'b0;
    neg_c = 1'b0;
    two_c = 1'b0;
    case (bsh_q[2:0])
      3'b001, 3'b010: pos_c = 1'b1;
      3'b011:         begin pos_c = 1'b1; two_c = 1'b1; end
      3'b100:         begin neg_c = 1'b1; two_c = 1'b1; end
      3'b101, 3'b110: neg_c = 1'b1;
      default:        ;
    endcase
  end

  // Partial product accumulate and early-exit detection
  always_comb begin
    pp_c        = two_c ? (msh_q << 1) : msh_q;
    prod_next_c = product;
    if (pos_c)      prod_next_c = product + pp_c;
    else if (neg_c) prod_next_c = product - pp_c;
    // bext[WIDTH:2i+1] all equal means every later digit recodes to zero
    rest_same_c = (&bsh_q[BW-1:2]) || (~|bsh_q[BW-1:2]);
    last_c      = (idx_q == CW'(NDIG - 1)) || rest_same_c;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_c) state_n = FIN;
      FIN:     state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      busy    <= (state_n == RUN);
      done    <= (state_n == FIN);
    end
  end

  // Datapath: operand latch on accept, one digit per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsh_q     <= '0;
      msh_q     <= '0;
      idx_q     <= '0;
      product   <= '0;
      add_count <= '0;
      sub_count <= '0;
    end else if (accept_c) begin
      bsh_q     <= {signed_mode & b[WIDTH-1], b, 1'b0};
      msh_q     <= {{WIDTH{signed_mode & a[WIDTH-1]}}, a};
      idx_q     <= '0;
      product   <= '0;
      add_count <= '0;
      sub_count <= '0;
    end else if (state_q == RUN) begin
      product   <= prod_next_c;
      bsh_q     <= {{2{bsh_q[BW-1]}}, bsh_q[BW-1:2]};
      msh_q     <= msh_q << 2;
      idx_q     <= idx_q + CW'(1);
      if (pos_c) add_count <= add_count + CW'(1);
      if (neg_c) sub_count <= sub_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
module tb_booth_r4_mult;

  typedef struct {
    logic [63:0] prod;
    int          adds;
    int          subs;
    int          m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst8_n, rst32_n;
  logic        start8, sm8, start32, sm32;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        busy8, done8, busy32, done32;
  logic [15:0] product8;
  logic [63:0] product32;
  logic [2:0]  add8, sub8;
  logic [4:0]  add32, sub32;

  int checks = 0;
  int failures = 0;
  int run8 = 0;
  int run32 = 0;
  exp_t q8[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  booth_r4_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8),
    .add_count(add8), .sub_count(sub8));

  booth_r4_mult #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst32_n), .start(start32), .signed_mode(sm32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .product(product32),
    .add_count(add32), .sub_count(sub32));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop expected result whenever done is presented
  always @(negedge clk) begin
    exp_t e;
    if (!rst8_n) run8 = 0;
    else begin
      if (busy8) run8++;
      if (done8) begin
        if (q8.size() == 0) chk("dut8_unexpected_done", 64'd1, 64'd0);
        else begin
          e = q8.pop_front();
          chk("dut8_product", 64'(product8), e.prod);
          chk("dut8_add_count", 64'(add8), 64'(e.adds));
          chk("dut8_sub_count", 64'(sub8), 64'(e.subs));
          chk("dut8_run_cycles", 64'(run8), 64'(e.m));
        end
        run8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst32_n) run32 = 0;
    else begin
      if (busy32) run32++;
      if (done32) begin
        if (q32.size() == 0) chk("dut32_unexpected_done", 64'd1, 64'd0);
        else begin
          e = q32.pop_front();
          chk("dut32_product", product32, e.prod);
          chk("dut32_add_count", 64'(add32), 64'(e.adds));
          chk("dut32_sub_count", 64'(sub32), 64'(e.subs));
          chk("dut32_run_cycles", 64'(run32), 64'(e.m));
        end
        run32 = 0;
      end
    end
  end

  task automatic go8(input logic sm, input logic [7:0] aa, input logic [7:0] bb,
                     input logic [15:0] ep, input int ea, input int es, input int em);
    exp_t e;
    e.prod = 64'(ep); e.adds = ea; e.subs = es; e.m = em;
    q8.push_back(e);
    sm8 = sm; a8 = aa; b8 = bb; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Leaves the bench positioned in the FIN cycle
  task automatic wait_done8();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done8) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen) chk("dut8_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done32();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done32) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen) chk("dut32_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run8_op(input logic sm, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [15:0] ep, input int ea, input int es, input int em);
    go8(sm, aa, bb, ep, ea, es, em);
    wait_done8();
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst8_n = 1'b0; rst32_n = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_product", 64'(product8), 64'd0);
    chk("rst_add_count", 64'(add8), 64'd0);
    chk("rst_sub_count", 64'(sub8), 64'd0);
    rst8_n = 1'b1; rst32_n = 1'b1;
    @(posedge clk); #1;

    run8_op(1'b1, 8'hF9, 8'h03, 16'hFFEB, 1, 1, 2);
    run8_op(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1, 1, 5);
    run8_op(1'b1, 8'hFF, 8'hFF, 16'h0001, 0, 1, 1);
    run8_op(1'b1, 8'h5A, 8'h00, 16'h0000, 0, 0, 1);
    run8_op(1'b0, 8'hFF, 8'h00, 16'h0000, 0, 0, 1);
    run8_op(1'b0, 8'h10, 8'h10, 16'h0100, 1, 0, 3);
    run8_op(1'b1, 8'h80, 8'h80, 16'h4000, 0, 1, 4);
    run8_op(1'b1, 8'h05, 8'hFD, 16'hFFF1, 1, 1, 2);

    // Start and operand changes during RUN must not disturb the product
    go8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1, 1, 5);
    @(posedge clk); #1;
    sm8 = 1'b1; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h77;
    wait_done8();
    @(posedge clk); #1;
    chk("ignored_start_idle", 64'(busy8), 64'd0);

    // Start in FIN launches back-to-back
    go8(1'b1, 8'h7F, 8'h7F, 16'h3F01, 1, 1, 4);
    wait_done8();
    go8(1'b0, 8'h10, 8'h10, 16'h0100, 1, 0, 3);
    chk("b2b_busy", 64'(busy8), 64'd1);
    wait_done8();
    @(posedge clk); #1;

    // Reset mid-RUN on the 32-bit instance
    sm32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h7FFF_FFFF; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("dut32_busy_before_rst", 64'(busy32), 64'd1);
    rst32_n = 1'b0;
    #1;
    chk("dut32_rst_busy", 64'(busy32), 64'd0);
    chk("dut32_rst_done", 64'(done32), 64'd0);
    chk("dut32_rst_product", product32, 64'd0);
    chk("dut32_rst_counts", 64'({add32, sub32}), 64'd0);
    @(posedge clk); #1;
    rst32_n = 1'b1;
    @(posedge clk); #1;
    e.prod = 64'hFFFF_FFFF_FFFF_FFF1; e.adds = 2; e.subs = 0; e.m = 2;
    q32.push_back(e);
    sm32 = 1'b1; a32 = 32'hFFFF_FFFD; b32 = 32'd5; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    wait_done32();

    repeat (4) @(posedge clk);
    #1;
    chk("dut8_queue_drained", 64'(q8.size()), 64'd0);
    chk("dut32_queue_drained", 64'(q32.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
